// File: rtl/inst_queue_pkg.sv
// Shared types for the instruction queue.
// Each entry pairs a fetched instruction with its PC.
package inst_queue_pkg;

    // Default queue depth used by the core-level instantiation
    localparam int IQ_DEPTH = 16;

    // One buffered fetch result
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } iq_entry_t;

    // Index bits of a wrap-bit pointer (drops the MSB)
    function automatic logic [31:0] iq_ptr_index(input logic [31:0] ptr, input int ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return ptr & mask;
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Instruction queue: circular FIFO of {inst, pc} between fetch and decode.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy register; count is their difference.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter  int DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_inst,
    input  logic [31:0]      enq_pc,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_inst,
    output logic [31:0]      deq_pc,
    output logic [PTR_W:0]   count
);

    iq_entry_t            r_mem [DEPTH];
    logic [PTR_W:0]       r_head;
    logic [PTR_W:0]       r_tail;

    logic [PTR_W-1:0]     w_head_idx;
    logic [PTR_W-1:0]     w_tail_idx;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_enq_fire;
    logic                 w_deq_fire;
    iq_entry_t            w_head_entry;
    iq_entry_t            w_enq_entry;

    assign w_head_idx = r_head[PTR_W-1:0];
    assign w_tail_idx = r_tail[PTR_W-1:0];

    // Full when indices match but the wrap bits differ; empty when equal
    assign w_empty = (r_head == r_tail);
    assign w_full  = (w_head_idx == w_tail_idx) && (r_head[PTR_W] != r_tail[PTR_W]);

    // Handshakes depend only on registered pointers (no bypass paths)
    assign enq_ready = !w_full;
    assign deq_valid = !w_empty;

    // A flush cycle drops both the enqueue and the dequeue
    assign w_enq_fire = enq_valid && !w_full  && !flush;
    assign w_deq_fire = !w_empty  && deq_ready && !flush;

    assign w_enq_entry = '{inst: enq_inst, pc: enq_pc};

    // Head entry is read combinationally from the registered array
    assign w_head_entry = r_mem[w_head_idx];
    assign deq_inst     = w_head_entry.inst;
    assign deq_pc       = w_head_entry.pc;

    assign count = r_tail - r_head;

    // Entry storage: zeroed on reset so deq_* is never X, written on enqueue
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_enq_fire) begin
            r_mem[w_tail_idx] <= w_enq_entry;
        end
    end

    // Pointer update: reset beats flush, flush beats any transfer
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_enq_fire) begin
                r_tail <= r_tail + (PTR_W+1)'(1);
            end
            if (w_deq_fire) begin
                r_head <= r_head + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed test-plan phases followed by
// randomized traffic, checked against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [31:0]      enq_inst;
    logic [31:0]      enq_pc;
    logic             deq_valid;
    logic             deq_ready;
    logic [31:0]      deq_inst;
    logic [31:0]      deq_pc;
    logic [PTR_W:0]   count;

    int errors = 0;
    int checks = 0;

    logic [63:0] model_q [$];
    bit          mon_en    = 1'b0;
    bit          enq_fired = 1'b0;
    logic [31:0] pc_ctr    = 32'h0000_1000;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_inst  (enq_inst),
        .enq_pc    (enq_pc),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_inst  (deq_inst),
        .deq_pc    (deq_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor on the falling edge: compare status with the model, then
    // apply whatever transfer the coming rising edge will perform.
    always @(negedge clk) begin
        int          sz;
        logic [63:0] exp_e;
        if (mon_en) begin
            sz = model_q.size();
            chk("deq_valid", {63'd0, deq_valid}, {63'd0, (sz != 0)});
            chk("enq_ready", {63'd0, enq_ready}, {63'd0, (sz < DEPTH)});
            chk("count", 64'(count), 64'(sz));
            enq_fired = 1'b0;
            if (rst || flush) begin
                model_q.delete();
            end else begin
                if (deq_ready && sz != 0) begin
                    exp_e = model_q.pop_front();
                    chk("deq_inst", {32'd0, deq_inst}, {32'd0, exp_e[63:32]});
                    chk("deq_pc",   {32'd0, deq_pc},   {32'd0, exp_e[31:0]});
                end
                if (enq_valid && sz < DEPTH) begin
                    model_q.push_back({enq_inst, enq_pc});
                    enq_fired = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq_cycle(input logic [31:0] i, input logic [31:0] p, input logic dr);
        enq_valid = 1'b1;
        enq_inst  = i;
        enq_pc    = p;
        deq_ready = dr;
        step();
    endtask

    task automatic enq_n(input int n, input logic dr);
        for (int k = 0; k < n; k++) begin
            enq_cycle($urandom, pc_ctr, dr);
            pc_ctr = pc_ctr + 32'd4;
        end
        enq_valid = 1'b0;
    endtask

    task automatic drain();
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        repeat (DEPTH + 2) step();
        deq_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        enq_inst = 32'd0; enq_pc = 32'd0;
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_deq_valid", {63'd0, deq_valid}, 64'd0);
        chk("rst_enq_ready", {63'd0, enq_ready}, 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_deq_inst", {32'd0, deq_inst}, 64'd0);
        chk("rst_deq_pc", {32'd0, deq_pc}, 64'd0);
        repeat (2) step();

        // Three in-order enqueues, then drain
        enq_cycle(32'h0050_0093, 32'h1ece_b000, 1'b0);
        chk("first_deq_valid", {63'd0, deq_valid}, 64'd1);
        enq_cycle(32'h00a0_0113, 32'h1ece_b004, 1'b0);
        enq_cycle(32'h0020_81b3, 32'h1ece_b008, 1'b0);
        enq_valid = 1'b0;
        chk("three_count", 64'(count), 64'd3);
        deq_ready = 1'b1;
        repeat (3) step();
        chk("three_empty", {63'd0, deq_valid}, 64'd0);
        deq_ready = 1'b0;
        step();

        // Fill, hold a rejected entry, free one slot
        enq_n(DEPTH, 1'b0);
        chk("full_count", 64'(count), 64'd16);
        chk("full_ready", {63'd0, enq_ready}, 64'd0);
        enq_valid = 1'b1;
        enq_inst  = 32'hcafe_0016;
        enq_pc    = 32'h0000_2000;
        repeat (2) step();
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        chk("ready_back", {63'd0, enq_ready}, 64'd1);
        step();
        enq_valid = 1'b0;
        chk("refill_count", 64'(count), 64'd16);
        drain();

        // Steady streaming across the wrap
        enq_n(5, 1'b0);
        for (int k = 0; k < 40; k++) begin
            enq_cycle($urandom, pc_ctr, 1'b1);
            pc_ctr = pc_ctr + 32'd4;
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        chk("stream_count", 64'(count), 64'd5);
        drain();

        // Flush with concurrent enqueue and dequeue
        enq_n(5, 1'b0);
        flush = 1'b1; enq_valid = 1'b1; deq_ready = 1'b1;
        enq_inst = 32'h1111_2222; enq_pc = 32'h0000_3000;
        step();
        flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", {63'd0, deq_valid}, 64'd0);
        chk("flush_ready", {63'd0, enq_ready}, 64'd1);
        enq_cycle(32'hdead_beef, 32'h0000_4000, 1'b0);
        enq_valid = 1'b0;
        chk("post_flush_head", {32'd0, deq_inst}, {32'd0, 32'hdead_beef});
        drain();

        // Reset and flush together while full
        enq_n(DEPTH, 1'b0);
        rst = 1'b1; flush = 1'b1; enq_valid = 1'b1; deq_ready = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        chk("rf_deq_inst", {32'd0, deq_inst}, 64'd0);
        chk("rf_deq_pc", {32'd0, deq_pc}, 64'd0);
        chk("rf_count", 64'(count), 64'd0);
        chk("rf_valid", {63'd0, deq_valid}, 64'd0);
        chk("rf_ready", {63'd0, enq_ready}, 64'd1);

        // Random traffic; a rejected entry is held stable until accepted
        for (int k = 0; k < 400; k++) begin
            if (!(enq_valid && !enq_fired)) begin
                enq_inst = $urandom;
                enq_pc   = pc_ctr;
                pc_ctr   = pc_ctr + 32'd4;
                enq_valid = ($urandom_range(0, 3) != 0);
            end
            deq_ready = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        flush = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular FIFO that buffers fetched instructions and their PCs between the fetch unit and the decode stage.
- Decouples fetch/I-cache latency from decode/dispatch stalls.
- The head entry is presented combinationally to decode, which splits it into opcode, fields and immediate.
- Flushed on redirect (branch mispredict / jalr resolution from commit).

Parameters:
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all entries (redirect)
- enq_valid  input  1  fetch presents an instruction
- enq_ready  output  1  queue can accept (not full)
- enq_inst  input  32  instruction word
- enq_pc  input  32  PC of enq_inst
- deq_valid  output  1  head entry valid (not empty)
- deq_ready  input  1  decode/dispatch consumes head this cycle
- deq_inst  output  32  head instruction word, feeds decode
- deq_pc  output  32  head PC
- count  output  PTR_W+1  number of valid entries

Behaviour:
- Storage:
  - DEPTH entries of {inst, pc}, plus head_ptr and tail_ptr of PTR_W+1 bits each.
  - The MSB is the wrap bit.
  - empty = (head == tail).
  - full = (index bits equal) and (wrap bits differ).
- Enqueue fires when enq_valid && enq_ready && !flush:
  - Writes entry[tail index] at the clock edge.
  - tail increments by 1, wrapping naturally modulo 2*DEPTH.
- Dequeue fires when deq_valid && deq_ready && !flush:
  - head increments by 1.
- Handshake rules:
  - enq_ready = !full, combinational from registered state only. It is never a function of deq_ready, so there is no same-cycle bypass when full.
  - deq_valid = !empty, registered state only. There is no enq-to-deq bypass: an entry written at edge N is visible on deq_* from cycle N+1.
  - deq_inst and deq_pc = entry[head index], a combinational read of the registered array.
  - deq_inst/deq_pc are don't-care when deq_valid=0, but must not be X after reset: the array is zeroed on reset.
  - Fetch must hold enq_inst/enq_pc stable while enq_valid && !enq_ready. Decode may drop deq_ready at any time.
- Simultaneous enqueue and dequeue:
  - Both pointers advance and count is unchanged.
  - Legal whenever not full and not empty.
  - When full, only dequeue can fire. When empty, only enqueue can fire.
- count = tail - head, PTR_W+1 bits, range 0..DEPTH. It updates at the same edge as the pointers.
- Flush:
  - Has priority over everything.
  - On the edge with flush=1: head <= 0, tail <= 0. Any enqueue and dequeue in that cycle are dropped (no write, no consume).
  - Next cycle: deq_valid=0, enq_ready=1, count=0.
  - Array contents are not cleared.
- Reset:
  - rst has priority over flush.
  - After the edge: head=tail=0, array zeroed, deq_valid=0, enq_ready=1, count=0, deq_inst=0, deq_pc=0.
  - rst mid-operation discards all entries with identical results.
- Wrap-around: pointers wrap from 2*DEPTH-1 to 0 with no special case. Entry order is FIFO across the wrap.

Decomposition:
- Add to the shared rv32i_types package:
  - iq_entry_t, a packed struct {logic [31:0] inst; logic [31:0] pc;}.
  - localparam IQ_DEPTH = 16, used by the top-level instantiation.
- No sub-module. Storage, pointers and full/empty logic fit in a single module of about 150 lines.
- The top level wires deq_inst directly into the decode instance's inst input.

Test Plan:
- Reset, then idle.
  - Required: deq_valid=0, enq_ready=1, count=0, deq_inst=0.
- Enqueue 3 entries with deq_ready=0: inst 0x00500093/pc 0x1eceb000, 0x00a00113/0x1eceb004, 0x002081b3/0x1eceb008. Then set deq_ready=1.
  - Required: deq_valid rises the cycle after the first enqueue.
  - Required: the entries come out in order with matching PCs, count goes 3,2,1,0, and deq_valid is low after the third dequeue.
- Fill DEPTH=16 entries.
  - Required: enq_ready=0 and count=16.
  - Then hold enq_valid=1 and pulse one dequeue. Required: enq_ready returns the next cycle, and the held entry lands as the 16th in order.
- Continuous enqueue and dequeue every cycle for 40 cycles (crossing the wrap twice).
  - Required: count is constant, order is preserved, and no entry is lost or duplicated.
- With 5 entries queued, assert flush together with enq_valid and deq_ready.
  - Required: the next cycle has count=0, deq_valid=0 and enq_ready=1. The flush-cycle enqueue is absent.
  - Required: the next enqueued inst appears at head.
- Assert rst and flush together while the queue is full.
  - Required: after the edge, the state equals post-reset state with deq_inst=0 and deq_pc=0.
